lfsr_deserializer: RTL and testbench

- Consumes the 1-bit pseudo-random stream from the 3-stage LFSR and packs it MSB-first into WORD_W-bit words.
- Buffers completed words in a small FIFO and presents them downstream over a valid/ready handshake.
- Discards partial words whenever the LFSR is reseeded (shared `ena`).
- Counts words dropped because the FIFO was full.

---
 rtl/lfsr_pkg.sv | 7 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/lfsr_deserializer.sv | 86 ++++++++
 tb/tb_lfsr_deserializer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared defaults and FSM encoding for the LFSR stream deserializer.
package lfsr_pkg;
  localparam int LFSR_WORD_W_DEFAULT     = 8;
  localparam int LFSR_FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic {S_SEED, S_COLLECT} deser_state_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head_data reads 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/lfsr_deserializer.sv
// Packs the LFSR serial stream MSB-first into words, buffers them and
// tracks words lost to a full buffer.
module lfsr_deserializer
  import lfsr_pkg::*;
#(
  parameter int WORD_W     = LFSR_WORD_W_DEFAULT,
  parameter int FIFO_DEPTH = LFSR_FIFO_DEPTH_DEFAULT,
  parameter int DROP_W     = 8,
  localparam int CW        = $clog2(WORD_W),
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [FCW-1:0]    fifo_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);
  deser_state_t      state, next_state;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt, cnt_base;
  logic              shift_en, word_done, pop, full, empty, drop;
  logic [WORD_W-1:0] push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_COLLECT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (ena) next_state = S_SEED;
    else     next_state = S_COLLECT;
  end

  // Reseed wins over a valid bit; while seeding the count is pinned to zero.
  always_comb begin
    shift_en = ~ena & bit_valid;
    cnt_base = (state == S_SEED) ? '0 : cnt;
  end

  assign word_done = shift_en && (cnt_base == CW'(WORD_W - 1));
  assign push_word = {shreg[WORD_W-2:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (shift_en) shreg <= push_word;
      if (ena)           cnt <= '0;
      else if (shift_en) cnt <= word_done ? '0 : cnt_base + 1'b1;
    end
  end

  assign word_valid = ~empty;
  assign pop        = word_valid & word_ready;
  assign drop       = word_done & full & ~pop;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (push_word),
    .pop       (pop),
    .head_data (word_out),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_lfsr_deserializer.sv
// Directed bench with a word scoreboard; a DROP_W=2 twin shares the stimulus
// to exercise counter saturation.
module tb_lfsr_deserializer;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int CNTW = $clog2(D) + 1;

  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0;
  logic [W-1:0]    word_out, s_word_out;
  logic            word_valid, s_word_valid, overflow, s_overflow;
  logic [CNTW-1:0] fifo_count, s_fifo_count;
  logic [7:0]      drop_count;
  logic [1:0]      s_drop_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  lfsr_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  lfsr_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .DROP_W(2)) dut_s (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(s_word_out), .word_valid(s_word_valid), .word_ready(word_ready),
    .fifo_count(s_fifo_count), .overflow(s_overflow), .drop_count(s_drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each pop the DUT is about to take must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && word_valid === 1'b1 && word_ready === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("pop_word", 32'(word_out), 32'(sb.pop_front()));
    end
  end

  task automatic step_bit(input logic b);
    ena = 1'b0; bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ena = 1'b0; bit_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_it);
    if (expect_it) sb.push_back(w);
    for (int i = W - 1; i >= 0; i--) step_bit(w[i]);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [7:0]   b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_word",  32'(word_out),   32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);

    // Basic packing, MSB first
    word_ready = 1'b1;
    b1 = 8'b1011_0010;
    sb.push_back(8'hB2);
    for (int i = 7; i >= 0; i--) step_bit(b1[i]);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_word",  32'(word_out),   32'hB2);
    idle(1);
    check("t1_valid_1cyc", 32'(word_valid), 32'd0);
    check("t1_count0",     32'(fifo_count), 32'd0);

    // Reseed mid-word discards the partial word
    step_bit(1'b1); step_bit(1'b1); step_bit(1'b1);
    ena = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send_word(8'h0F, 1'b1);
    idle(3);
    check("t2_sb_drained", 32'(sb.size()), 32'd0);
    check("t2_valid",      32'(word_valid), 32'd0);

    // Backpressure and overflow
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_word(W'(k), k <= 4);
    check("t3_count", 32'(fifo_count), 32'd4);
    check("t3_ovf",   32'(overflow),   32'd1);
    check("t3_drop",  32'(drop_count), 32'd1);
    idle(2);
    check("t3_stable", 32'(word_out), 32'h01);
    word_ready = 1'b1;
    idle(6);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);
    check("t3_count0",     32'(fifo_count), 32'd0);

    rst = 1'b1; sb.delete(); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Full FIFO with simultaneous push and pop
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), 1'b1);
    w = 8'h15;
    sb.push_back(w);
    for (int i = W - 1; i >= 1; i--) step_bit(w[i]);
    word_ready = 1'b1;
    step_bit(w[0]);
    word_ready = 1'b0;
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_ovf",   32'(overflow),   32'd0);
    check("t4_drop",  32'(drop_count), 32'd0);
    word_ready = 1'b1;
    idle(6);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);

    // Saturation of the narrow drop counter
    word_ready = 1'b0;
    for (int k = 0; k < D + 5; k++) send_word(W'(8'h31 + k), k < D);
    check("t6_sat_drop",  32'(s_drop_count), 32'd3);
    check("t6_sat_ovf",   32'(s_overflow),   32'd1);
    check("t6_sat_count", 32'(s_fifo_count), 32'd4);
    check("t6_wide_drop", 32'(drop_count),   32'd5);
    word_ready = 1'b1;
    idle(6);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset between edges
    word_ready = 1'b0;
    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b0);
    for (int i = 0; i < 5; i++) step_bit(1'b1);
    check("t5_pre_count", 32'(fifo_count), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("t5_valid", 32'(word_valid), 32'd0);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_drop",  32'(drop_count), 32'd0);
    check("t5_ovf",   32'(overflow),   32'd0);
    #1 rst = 1'b0;
    bit_valid = 1'b0;
    @(posedge clk); #1;
    word_ready = 1'b1;
    send_word(8'hA5, 1'b1);
    check("t5_word", 32'(word_out), 32'hA5);
    idle(3);
    check("t5_sb_drained", 32'(sb.size()), 32'd0);
    check("t5_valid_end",  32'(word_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
